stack_memory: RTL

- LIFO data stack that responds to the push/pop strobes issued by the calculator's memory controller.
- Stores operands entered from the switches and results returned from the ALU.
- The top-of-stack is always visible on memOut, so the controller can sample it while issuing a pop.
- Sits between the memory controller and the display path; count, empty and full also drive status LEDs.

---
 rtl/stack_memory_pkg.sv | 7 +
 rtl/stack_memory_ram.sv | 27 ++
 rtl/stack_memory.sv | 124 ++++++++++++
 3 files changed

// File: rtl/stack_memory_pkg.sv
// Shared stack constants, also used by the controller and display path.
package stack_memory_pkg;

    localparam int unsigned STACK_WIDTH = 32;
    localparam int unsigned STACK_DEPTH = 16;

endpackage : stack_memory_pkg

// File: rtl/stack_memory_ram.sv
// Stack storage: one synchronous write port, one asynchronous read port.
module stack_ram
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata_c
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Array contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[i_raddr];

endmodule : stack_ram

// File: rtl/stack_memory.sv
// LIFO operand stack with a registered top-of-stack output and sticky error flags.
module stack_memory
    import stack_memory_pkg::*;
#(
    parameter int unsigned WIDTH = STACK_WIDTH,
    parameter int unsigned DEPTH = STACK_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] memIn,
    output logic [WIDTH-1:0] memOut,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned CW = AW + 1;

    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_mem_out;
    logic             r_ovf;
    logic             r_udf;

    logic             w_empty;
    logic             w_full;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [AW-1:0]    w_raddr;
    logic [WIDTH-1:0] w_rdata;
    logic [CW-1:0]    w_nxt_count;
    logic [WIDTH-1:0] w_nxt_out;
    logic             w_set_ovf;
    logic             w_set_udf;

    assign w_empty = (r_count == CW'(0));
    assign w_full  = (r_count == CW'(DEPTH));
    // Entry just below the top; becomes the new top after a pop.
    assign w_raddr = AW'(r_count - CW'(2));

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (memIn),
        .i_raddr   (w_raddr),
        .o_rdata_c (w_rdata)
    );

    // Operation decode: push, pop, replace-top, or refuse with a sticky flag.
    always_comb begin
        w_we        = 1'b0;
        w_waddr     = AW'(r_count);
        w_nxt_count = r_count;
        w_nxt_out   = r_mem_out;
        w_set_ovf   = 1'b0;
        w_set_udf   = 1'b0;
        unique case ({push, pop})
            2'b10: begin
                if (w_full) begin
                    w_set_ovf = 1'b1;
                end else begin
                    w_we        = 1'b1;
                    w_nxt_out   = memIn;
                    w_nxt_count = r_count + CW'(1);
                end
            end
            2'b01: begin
                if (w_empty) begin
                    w_set_udf = 1'b1;
                end else if (r_count == CW'(1)) begin
                    w_nxt_count = CW'(0);
                    w_nxt_out   = '0;
                end else begin
                    w_nxt_count = r_count - CW'(1);
                    w_nxt_out   = w_rdata;
                end
            end
            2'b11: begin
                // Replace the top; on an empty stack this is a plain push.
                w_we      = 1'b1;
                w_nxt_out = memIn;
                if (w_empty) begin
                    w_nxt_count = CW'(1);
                end else begin
                    w_waddr = AW'(r_count - CW'(1));
                end
            end
            default: begin
            end
        endcase
    end

    // Pointer, top-of-stack register and sticky flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count   <= '0;
            r_mem_out <= '0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else begin
            r_count   <= w_nxt_count;
            r_mem_out <= w_nxt_out;
            r_ovf     <= r_ovf | w_set_ovf;
            r_udf     <= r_udf | w_set_udf;
        end
    end

    assign memOut    = r_mem_out;
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_ovf;
    assign underflow = r_udf;

endmodule : stack_memory
